pipeline_hazard_ctrl: RTL

//  Central stall/flush/forward sequencer for the 5-stage RV32I pipeline.

---
 rtl/pipe_ctrl_defs_pkg.sv | 15 +
 rtl/fwd_unit.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_defs_pkg.sv
// Shared encodings for the pipeline hazard controller:
// sequencer states and EX operand forwarding selects.
package pipe_ctrl_defs;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for one source register.
// The younger EX/MEM result wins over MEM/WB; x0 never forwards.
module fwd_unit
   import pipe_ctrl_defs::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] mem_rd,
   input  logic       mem_reg_write,
   input  logic [4:0] wb_rd,
   input  logic       wb_reg_write,
   output logic [1:0] fwd
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_reg_write & (mem_rd != 5'd0) & (mem_rd == rs);
   assign wb_hit  = wb_reg_write & (wb_rd != 5'd0) & (wb_rd == rs);

   always_comb begin
      fwd = FWD_RF;
      if (mem_hit)
         fwd = FWD_EXMEM;
      else if (wb_hit)
         fwd = FWD_MEMWB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage RV32I pipeline,
// including the ebreak drain/halt/resume sequence.
module pipeline_hazard_ctrl
   import pipe_ctrl_defs::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs0,
   input  logic [4:0]       id_rs1,
   input  logic             id_use0,
   input  logic             id_use1,
   input  logic [4:0]       ex_rs0,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_to_reg,
   input  logic             ex_nop,
   input  logic             ex_ebreak,
   input  logic             ex_redirect,
   input  logic [4:0]       mem_rd,
   input  logic [4:0]       wb_rd,
   input  logic             mem_reg_write,
   input  logic             wb_reg_write,
   input  logic             dmem_busy,
   input  logic             resume,
   output logic             pc_stop,
   output logic             ifid_stop,
   output logic             ifid_clr,
   output logic             idex_stop,
   output logic             idex_clr,
   output logic             exmem_stop,
   output logic             exmem_clr,
   output logic             memwb_stop,
   output logic             memwb_clr,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             halt_capture,
   output logic             resume_jump,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

   state_t         state;
   state_t         state_nxt;
   logic [DW-1:0]  drain_cnt;
   logic [DW-1:0]  drain_nxt;
   logic           resume_jump_q;
   logic           freeze;
   logic           load_use;

   assign load_use = ex_mem_to_reg & ~ex_nop & (ex_rd != 5'd0)
                   & ((id_use0 & (id_rs0 == ex_rd))
                   |  (id_use1 & (id_rs1 == ex_rd)));

   // HALTED holds every register exactly like a data-memory wait does
   assign freeze = dmem_busy | (state == HALTED);

   always_comb begin
      pc_stop      = 1'b0;
      ifid_stop    = 1'b0;
      idex_stop    = 1'b0;
      exmem_stop   = 1'b0;
      memwb_stop   = 1'b0;
      ifid_clr     = 1'b0;
      idex_clr     = 1'b0;
      exmem_clr    = 1'b0;
      memwb_clr    = 1'b0;
      halt_capture = 1'b0;
      state_nxt    = state;
      drain_nxt    = drain_cnt;
      if (freeze) begin
         pc_stop    = 1'b1;
         ifid_stop  = 1'b1;
         idex_stop  = 1'b1;
         exmem_stop = 1'b1;
         memwb_stop = 1'b1;
      end
      unique case (state)
         RUN: begin
            if (dmem_busy) begin
            end else if (ex_ebreak & ~ex_nop) begin
               pc_stop      = 1'b1;
               ifid_clr     = 1'b1;
               idex_clr     = 1'b1;
               halt_capture = 1'b1;
               state_nxt    = DRAIN;
               drain_nxt    = DRAIN_INIT;
            end else if (ex_redirect) begin
               ifid_clr = 1'b1;
               idex_clr = 1'b1;
            end else if (load_use) begin
               pc_stop   = 1'b1;
               ifid_stop = 1'b1;
               idex_clr  = 1'b1;
            end
         end
         DRAIN: begin
            if (!dmem_busy) begin
               pc_stop  = 1'b1;
               ifid_clr = 1'b1;
               idex_clr = 1'b1;
               if (drain_cnt == DW'(1))
                  state_nxt = HALTED;
               else
                  drain_nxt = drain_cnt - 1'b1;
            end
         end
         HALTED: begin
            if (resume)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
      if (!rst_n) begin
         pc_stop      = 1'b0;
         ifid_stop    = 1'b0;
         idex_stop    = 1'b0;
         exmem_stop   = 1'b0;
         memwb_stop   = 1'b0;
         ifid_clr     = 1'b1;
         idex_clr     = 1'b1;
         exmem_clr    = 1'b1;
         memwb_clr    = 1'b1;
         halt_capture = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RUN;
         drain_cnt     <= '0;
         resume_jump_q <= 1'b0;
         stall_cycles  <= '0;
      end else begin
         state         <= state_nxt;
         drain_cnt     <= drain_nxt;
         resume_jump_q <= (state == HALTED) & resume;
         if (pc_stop && !(&stall_cycles))
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

   assign resume_jump = resume_jump_q;
   assign halted      = (state == HALTED);

   fwd_unit u_fwd_a (
      .rs            (ex_rs0),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .fwd           (fwd_a)
   );

   fwd_unit u_fwd_b (
      .rs            (ex_rs1),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .fwd           (fwd_b)
   );

endmodule
